mem_bus_arbiter: RTL and testbench

Shares one external memory port between the instruction-fetch requester (IF stage) and the data-access requester (MEM stage), so the core can run against a single unified memory. It serialises accesses through a small state machine and gives data accesses priority, with a starvation limit that protects fetch. It converts the memory's single `m_ack_n` into per-requester active-low acknowledges. It sits between the core's IAD/IDT/ACKI_n and DAD/DDT/MREQ/WRITE/SIZE/ACKD_n buses and the memory.

---
 rtl/mem_arb_pkg.sv | 6 +
 rtl/mem_bus_arbiter_fetch_buf.sv | 34 +++
 rtl/mem_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory bus arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam int CNT_W = 4;
endpackage

// File: rtl/mem_bus_arbiter_fetch_buf.sv
// One-entry fetch buffer: holds the last fetched word, hit compare, write invalidate.
module fetch_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        fill,
  input  logic [29:0] fill_addr,
  input  logic [31:0] fill_data,
  input  logic        inval,
  input  logic [29:0] inval_addr,
  input  logic [29:0] lookup_addr,
  output logic        hit,
  output logic [31:0] hit_data
);
  logic        valid;
  logic [29:0] tag;
  logic [31:0] data;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_addr;
      data  <= fill_data;
    end else if (inval && inval_addr == tag) begin
      valid <= 1'b0;
    end
  end

  assign hit      = valid && (tag == lookup_addr);
  assign hit_data = data;
endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates IF fetches and MEM data accesses onto one memory port; data wins
// until STARVE_LIMIT, then fetch. Optional fetch buffer: MEM_ARB_FETCH_BUF_EN.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_ack_n,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack_n,
  output logic        m_req,
  output logic        m_write,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack_n
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_cnt;
  logic             grant_i, grant_d, hit_go, done;
  logic             buf_hit;
  logic [31:0]      buf_data;

`ifdef MEM_ARB_FETCH_BUF_EN
  fetch_buf u_fetch_buf (
    .clk        (clk),
    .rst        (rst),
    .fill       (done && state_q == BUSY_I),
    .fill_addr  (m_addr[31:2]),
    .fill_data  (m_rdata),
    .inval      (grant_d && d_write),
    .inval_addr (d_addr[31:2]),
    .lookup_addr(if_addr[31:2]),
    .hit        (buf_hit),
    .hit_data   (buf_data)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    hit_go  = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req && !(if_req && starve_cnt == LIMIT)) begin
          grant_d = 1'b1;
          state_d = BUSY_D;
        end else if (if_req) begin
          if (buf_hit && !d_req) begin
            hit_go  = 1'b1;
            state_d = RESP;
          end else begin
            grant_i = 1'b1;
            state_d = BUSY_I;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (!m_ack_n) begin
          done    = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      starve_cnt <= '0;
      m_req      <= 1'b0;
      m_write    <= 1'b0;
      m_size     <= SIZE_WORD;
      m_addr     <= '0;
      m_wdata    <= '0;
      if_data    <= '0;
      d_rdata    <= '0;
      if_ack_n   <= 1'b1;
      d_ack_n    <= 1'b1;
    end else begin
      state_q  <= state_d;
      if_ack_n <= 1'b1;
      d_ack_n  <= 1'b1;
      if (grant_d) begin
        m_req   <= 1'b1;
        m_write <= d_write;
        m_size  <= d_size;
        m_addr  <= d_addr;
        m_wdata <= d_write ? d_wdata : '0;
      end
      if (grant_i) begin
        m_req   <= 1'b1;
        m_write <= 1'b0;
        m_size  <= SIZE_WORD;
        m_addr  <= if_addr;
        m_wdata <= '0;
      end
      if (done) begin
        m_req <= 1'b0;
        if (state_q == BUSY_I) begin
          if_data  <= m_rdata;
          if_ack_n <= 1'b0;
        end else begin
          d_rdata <= m_rdata;
          d_ack_n <= 1'b0;
        end
      end
      if (hit_go) begin
        if_data  <= buf_data;
        if_ack_n <= 1'b0;
      end
      // A buffered fetch satisfies the waiting requester just like a fetch grant.
      if ((state_q == IDLE && !if_req) || grant_i || hit_go)
        starve_cnt <= '0;
      else if (grant_d && starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a wait-state configurable memory model.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_write;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [1:0]  d_size;
  logic [31:0] if_data, d_rdata, m_addr, m_wdata, m_rdata;
  logic        if_ack_n, d_ack_n, m_req, m_write, m_ack_n;
  logic [1:0]  m_size;
  int          errors = 0;
  int          checks = 0;
  int          wait_cfg = 0;
  int          busy_cyc = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_ack_n(if_ack_n),
    .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack_n(d_ack_n),
    .m_req(m_req), .m_write(m_write), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack_n(m_ack_n)
  );

  // Memory: acks after wait_cfg stall cycles; 0x100 holds a NOP, elsewhere ~addr.
  assign m_ack_n = !(m_req && busy_cyc == wait_cfg);
  assign m_rdata = (m_addr == 32'h100) ? 32'h0000_0013 : ~m_addr;
  always @(posedge clk) busy_cyc <= (m_req && m_ack_n) ? busy_cyc + 1 : 0;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (!if_ack_n && !d_ack_n) begin
        errors++;
        $display("FAIL ack_overlap: if_ack_n=%b d_ack_n=%b want never both 0", if_ack_n, d_ack_n);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; if_req = 0; d_req = 0; d_write = 0; d_size = 2'b10;
    if_addr = 0; d_addr = 0; d_wdata = 0; wait_cfg = 0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 0; d_req = 0; d_write = 0; d_size = 2'b01;
    if_addr = 0; d_addr = 0; d_wdata = 0; wait_cfg = 0;
    step(); step();
    checks++;
    if (m_req !== 1'b0 || m_write !== 1'b0 || m_size !== 2'b10 || m_addr !== 32'h0 || m_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem: req=%b wr=%b size=%b addr=%h wdata=%h want 0 0 10 0 0", m_req, m_write, m_size, m_addr, m_wdata);
    end
    checks++;
    if (if_data !== 32'h0 || d_rdata !== 32'h0 || if_ack_n !== 1'b1 || d_ack_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_core: if_data=%h d_rdata=%h if_ack_n=%b d_ack_n=%b want 0 0 1 1", if_data, d_rdata, if_ack_n, d_ack_n);
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch_only();
    do_reset();
    if_req = 1; if_addr = 32'h100;
    step();
    checks++;
    if (m_req !== 1'b1 || m_addr !== 32'h100 || m_size !== 2'b10 || m_write !== 1'b0 || if_ack_n !== 1'b1) begin
      errors++;
      $display("FAIL fetch_t1: req=%b addr=%h size=%b wr=%b ack_n=%b want 1 100 10 0 1", m_req, m_addr, m_size, m_write, if_ack_n);
    end
    step();
    checks++;
    if (if_ack_n !== 1'b0 || if_data !== 32'h13 || m_req !== 1'b0 || d_ack_n !== 1'b1) begin
      errors++;
      $display("FAIL fetch_t2: ack_n=%b data=%h req=%b d_ack_n=%b want 0 13 0 1", if_ack_n, if_data, m_req, d_ack_n);
    end
    if_req = 0;
    step();
    checks++;
    if (if_ack_n !== 1'b1 || if_data !== 32'h13 || dut.state_q !== mem_arb_pkg::IDLE) begin
      errors++;
      $display("FAIL fetch_t3: ack_n=%b data=%h state=%0d want 1 13 IDLE", if_ack_n, if_data, dut.state_q);
    end
  endtask

  task automatic test_priority();
    do_reset();
    if_req = 1; if_addr = 32'h104;
    d_req = 1; d_write = 0; d_size = 2'b10; d_addr = 32'h200; d_wdata = 32'h1234_5678;
    step();
    checks++;
    if (m_req !== 1'b1 || m_addr !== 32'h200 || m_write !== 1'b0 || m_wdata !== 32'h0) begin
      errors++;
      $display("FAIL prio_dgrant: req=%b addr=%h wr=%b wdata=%h want 1 200 0 0", m_req, m_addr, m_write, m_wdata);
    end
    step();
    checks++;
    if (d_ack_n !== 1'b0 || d_rdata !== 32'hFFFF_FDFF || if_ack_n !== 1'b1) begin
      errors++;
      $display("FAIL prio_dack: d_ack_n=%b d_rdata=%h if_ack_n=%b want 0 fffffdff 1", d_ack_n, d_rdata, if_ack_n);
    end
    d_req = 0;
    step(); step();
    checks++;
    if (m_req !== 1'b1 || m_addr !== 32'h104 || m_size !== 2'b10) begin
      errors++;
      $display("FAIL prio_igrant: req=%b addr=%h size=%b want 1 104 10", m_req, m_addr, m_size);
    end
    step();
    checks++;
    if (if_ack_n !== 1'b0 || if_data !== 32'hFFFF_FEFB || d_rdata !== 32'hFFFF_FDFF) begin
      errors++;
      $display("FAIL prio_iack: ack_n=%b data=%h d_rdata=%h want 0 fffffefb fffffdff", if_ack_n, if_data, d_rdata);
    end
    if_req = 0;
    step();
  endtask

  task automatic test_starvation();
    logic [31:0] seen [6];
    logic [31:0] exp  [6];
    int          gcnt = 0;
    logic        prev = 1'b0;
    exp = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h108, 32'h300};
    do_reset();
    if_req = 1; if_addr = 32'h108;
    d_req = 1; d_write = 0; d_addr = 32'h300;
    for (int c = 0; c < 40 && gcnt < 6; c++) begin
      step();
      if (m_req && !prev) begin
        seen[gcnt] = m_addr;
        gcnt++;
      end
      prev = m_req;
    end
    checks++;
    if (gcnt !== 6) begin
      errors++;
      $display("FAIL starve_count: grants=%0d want 6 within 40 cycles", gcnt);
    end
    for (int g = 0; g < 6; g++) begin
      if (g < gcnt) begin
        checks++;
        if (seen[g] !== exp[g]) begin
          errors++;
          $display("FAIL starve_grant%0d: addr=%h want %h", g, seen[g], exp[g]);
        end
      end
    end
    if_req = 0; d_req = 0;
    step(); step(); step();
  endtask

  task automatic test_store_wait();
    int acks = 0;
    do_reset();
    wait_cfg = 2;
    d_req = 1; d_write = 1; d_size = 2'b00; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (m_req !== 1'b1 || m_write !== 1'b1 || m_wdata !== 32'hDEAD_BEEF || m_size !== 2'b00 ||
          m_addr !== 32'h40 || d_ack_n !== 1'b1) begin
        errors++;
        $display("FAIL store_busy%0d: req=%b wr=%b wdata=%h size=%b addr=%h ack_n=%b want 1 1 deadbeef 00 40 1",
                 c, m_req, m_write, m_wdata, m_size, m_addr, d_ack_n);
      end
    end
    for (int c = 0; c < 4; c++) begin
      step();
      if (!d_ack_n) begin
        acks++;
        d_req = 0;
      end
    end
    checks++;
    if (acks !== 1) begin
      errors++;
      $display("FAIL store_ack: d_ack_n low %0d cycles want 1", acks);
    end
  endtask

  task automatic test_reset_busy();
    int acks = 0;
    do_reset();
    wait_cfg = 3;
    if_req = 1; if_addr = 32'h10C;
    d_req = 1; d_write = 0; d_addr = 32'h500;
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if (m_req !== 1'b0 || dut.state_q !== mem_arb_pkg::IDLE || dut.starve_cnt !== 4'd0 ||
        d_ack_n !== 1'b1 || if_ack_n !== 1'b1) begin
      errors++;
      $display("FAIL rst_busy: req=%b state=%0d cnt=%0d d_ack_n=%b if_ack_n=%b want 0 IDLE 0 1 1",
               m_req, dut.state_q, dut.starve_cnt, d_ack_n, if_ack_n);
    end
    rst = 1'b0; if_req = 0; d_req = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (!d_ack_n || !if_ack_n || m_req) acks++;
    end
    checks++;
    if (acks !== 0) begin
      errors++;
      $display("FAIL rst_noack: %0d cycles with ack or m_req after reset want 0", acks);
    end
    wait_cfg = 0;
  endtask

`ifdef MEM_ARB_FETCH_BUF_EN
  task automatic test_fetch_buf();
    do_reset();
    if_req = 1; if_addr = 32'h100;
    step(); step();
    if_req = 0;
    step(); step();
    if_req = 1;
    step();
    checks++;
    if (if_ack_n !== 1'b0 || if_data !== 32'h13 || m_req !== 1'b0) begin
      errors++;
      $display("FAIL buf_hit: ack_n=%b data=%h req=%b want 0 13 0", if_ack_n, if_data, m_req);
    end
    if_req = 0;
    step();
    d_req = 1; d_write = 1; d_size = 2'b10; d_addr = 32'h100; d_wdata = 32'h55;
    step(); step();
    d_req = 0;
    step(); step();
    if_req = 1;
    step();
    checks++;
    if (m_req !== 1'b1 || m_addr !== 32'h100 || if_ack_n !== 1'b1) begin
      errors++;
      $display("FAIL buf_inval: req=%b addr=%h ack_n=%b want 1 100 1", m_req, m_addr, if_ack_n);
    end
    step();
    if_req = 0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_only();
    test_priority();
    test_starvation();
    test_store_wait();
    test_reset_busy();
`ifdef MEM_ARB_FETCH_BUF_EN
    test_fetch_buf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
